// File: rtl/pbit_pkg.sv
// Shared Q8.24 constants, scheduler state encoding and the saturating
// add/subtract used by the local-field accumulator.
package pbit_pkg;

  localparam int INT_SIZE   = 8;
  localparam int FLOAT_SIZE = 24;
  localparam int DATA_W     = INT_SIZE + FLOAT_SIZE;

  localparam logic [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_SETTLE = 2'd2,
    S_SAMPLE = 2'd3
  } sched_state_t;

  // One guard bit catches overflow; the guard and sign disagree exactly when
  // the true result left the representable range.
  function automatic logic [DATA_W-1:0] sat_addsub(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sub
  );
    logic [DATA_W:0] ext;
    logic [DATA_W-1:0] res;
    if (sub) begin
      ext = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    end else begin
      ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    end
    if (ext[DATA_W] != ext[DATA_W-1]) begin
      res = ext[DATA_W] ? Q_MIN : Q_MAX;
    end else begin
      res = ext[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pbit_field_accum.sv
// Local-field accumulator: loads a bias, then adds or subtracts coupling
// terms with saturation depending on the neighbour spin.
module pbit_field_accum
  import pbit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] coef,
  input  logic              spin,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_next
);

  // spin=1 contributes +J, spin=0 contributes -J; load has priority
  always_comb begin
    acc_next = acc;
    if (load) begin
      acc_next = bias;
    end else if (step) begin
      acc_next = sat_addsub(acc, coef, ~spin);
    end else begin
      acc_next = acc;
    end
  end

  // accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= {DATA_W{1'b0}};
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pbit_gibbs_scheduler.sv
// Sequential Gibbs controller time-sharing one external pbit across N nodes:
// field accumulation, pbit settle window, sample and write-back per node.
module pbit_gibbs_scheduler
  import pbit_pkg::*;
#(
  parameter int N        = 8,
  parameter int PBIT_LAT = 2,
  parameter int ADDR_W   = 7,
  parameter int SWEEP_W  = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  output logic [DATA_W-1:0]  pbit_z,
  input  logic               pbit_val,
  output logic [N-1:0]       state,
  output logic               busy,
  output logic               sweep_done,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (PBIT_LAT > 1) ? $clog2(PBIT_LAT + 1) : 1;

  sched_state_t cur, nxt;

  logic [DATA_W-1:0]  jm [N][N];
  logic [DATA_W-1:0]  hv [N];
  logic [IW-1:0]      i, j, next_i, bias_idx;
  logic [LW-1:0]      lat;
  logic [SWEEP_W-1:0] sweeps_lat;
  logic [SWEEP_W-1:0] count_inc;
  logic               stop_pend;
  logic               last_node, run_end;
  logic               acc_load, acc_step;
  logic [DATA_W-1:0]  acc, acc_next;
  logic               cfg_ok;

  assign last_node = (i == IW'(N - 1));
  assign next_i    = last_node ? {IW{1'b0}} : i + IW'(1);
  assign count_inc = sweep_count + SWEEP_W'(1);
  assign cfg_ok    = cfg_we && !busy && (cur == S_IDLE);
  // The count compared here is the one this SAMPLE is about to produce
  assign run_end   = stop_pend || stop ||
                     (last_node && (sweeps_lat != {SWEEP_W{1'b0}}) && (count_inc == sweeps_lat));
  assign bias_idx  = (cur == S_SAMPLE) ? next_i : {IW{1'b0}};

  pbit_field_accum u_accum (
    .clk      (CLK),
    .rst      (RST),
    .load     (acc_load),
    .step     (acc_step),
    .bias     (hv[bias_idx]),
    .coef     (jm[i][j]),
    .spin     (state[j]),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // next-state and accumulator control
  always_comb begin
    nxt      = cur;
    acc_load = 1'b0;
    acc_step = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start) begin
          nxt      = S_ACCUM;
          acc_load = 1'b1;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        acc_step = (j != i);
        if (j == IW'(N - 1)) begin
          nxt = S_SETTLE;
        end else begin
          nxt = S_ACCUM;
        end
      end
      S_SETTLE: begin
        if (lat == LW'(PBIT_LAT - 1)) begin
          nxt = S_SAMPLE;
        end else begin
          nxt = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        if (run_end) begin
          nxt = S_IDLE;
        end else begin
          nxt      = S_ACCUM;
          acc_load = 1'b1;
        end
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // coupling and bias memory, writable only while idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < N; r++) begin
        hv[r] <= {DATA_W{1'b0}};
        for (int c = 0; c < N; c++) begin
          jm[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else if (cfg_ok) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (cfg_addr == ADDR_W'(r * N + c)) begin
            jm[r][c] <= cfg_data;
          end
        end
        if (cfg_addr == ADDR_W'(N * N + r)) begin
          hv[r] <= cfg_data;
        end
      end
    end
  end

  // node/sweep sequencing, spin state and status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i           <= {IW{1'b0}};
      j           <= {IW{1'b0}};
      lat         <= {LW{1'b0}};
      sweeps_lat  <= {SWEEP_W{1'b0}};
      sweep_count <= {SWEEP_W{1'b0}};
      stop_pend   <= 1'b0;
      state       <= {N{1'b0}};
      pbit_z      <= {DATA_W{1'b0}};
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      done        <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      done       <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (cfg_ok && (cfg_addr == ADDR_W'(N * N + N))) begin
            state <= cfg_data[N-1:0];
          end
          // stop in the same cycle as start is deliberately not latched
          if (start) begin
            sweeps_lat  <= sweeps;
            sweep_count <= {SWEEP_W{1'b0}};
            i           <= {IW{1'b0}};
            j           <= {IW{1'b0}};
            stop_pend   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (j == IW'(N - 1)) begin
            j      <= {IW{1'b0}};
            lat    <= {LW{1'b0}};
            pbit_z <= acc_next;
          end else begin
            j <= j + IW'(1);
          end
        end
        S_SETTLE: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          lat <= lat + LW'(1);
        end
        S_SAMPLE: begin
          state[i]  <= pbit_val;
          stop_pend <= 1'b0;
          i         <= next_i;
          if (last_node) begin
            sweep_count <= count_inc;
            sweep_done  <= 1'b1;
          end
          if (run_end) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pbit_gibbs_scheduler.md
Name: pbit_gibbs_scheduler

Overview:
- Sequential Gibbs-sampling controller that time-shares one pbit instance across N logical p-bits.
- For each node i it accumulates the local field z_i = h_i + sum over j≠i of J[i][j]*m_j, where m_j = +1 if state[j]=1, else -1.
- It drives z_i to the pbit, waits for the pbit pipeline to settle, samples pbit_val and writes the result back into state[i].
- It sits between the host/config bus and the pbit datapath. Fixed-point format is signed Q8.24 (32 bits), matching the pbit z input.

Parameters:
- N, 8, number of logical p-bits
- INT_SIZE, 8, integer bits of fixed-point word
- FLOAT_SIZE, 24, fraction bits of fixed-point word
- PBIT_LAT, 2, cycles z must be held stable before pbit_val is valid (covers tanh + RNG pipeline)
- ADDR_W, 7, config address width; must satisfy 2^ADDR_W > N*N+N
- SWEEP_W, 16, width of sweep counter

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a run; accepted only in IDLE
- stop  in  1  abort request; honoured at next node boundary
- sweeps  in  SWEEP_W  number of full sweeps per run, sampled on start; 0 = run until stop
- cfg_we  in  1  config write strobe; ignored while busy=1
- cfg_addr  in  ADDR_W  0..N*N-1 = J[i][j] at i*N+j; N*N..N*N+N-1 = h[i]; N*N+N = state init (low N bits)
- cfg_data  in  32  Q8.24 write data
- pbit_z  out  32  local field presented to pbit z input
- pbit_val  in  1  pbit output
- state  out  N  current p-bit states
- busy  out  1  high from the cycle after start acceptance until done
- sweep_done  out  1  one-cycle pulse after the last node of each sweep
- done  out  1  one-cycle pulse when a run ends (sweep count reached or stop)
- sweep_count  out  SWEEP_W  sweeps completed in the current or last run

Behaviour:
- Reset (async, any state): FSM=IDLE; all J, h, state, pbit_z, sweep_count = 0; busy, sweep_done, done = 0.
- States: IDLE -> ACCUM -> SETTLE -> SAMPLE -> (ACCUM | IDLE).
- IDLE: cfg writes take effect the next cycle. start=1 latches sweeps, clears sweep_count, sets i=0, acc=h[0]; next state ACCUM.
- ACCUM: N cycles, j=0..N-1. acc += J[i][j] if state[j]=1, acc -= J[i][j] if state[j]=0. Skip when j==i.
- Each add/sub saturates to 0x7FFFFFFF / 0x80000000.
- SETTLE: pbit_z = acc, registered on ACCUM exit. Hold for PBIT_LAT cycles.
- pbit_z holds its last value at all other times.
- SAMPLE: 1 cycle. state[i] <= pbit_val.
  - If i==N-1: i=0, sweep_count++, sweep_done=1.
  - Run ends if sweeps≠0 and sweep_count reaches sweeps, or stop was seen since the last boundary. On end: IDLE, done=1, busy=0 next cycle.
  - Otherwise: i++, acc=h[i], back to ACCUM.
- Per-node period: N+PBIT_LAT+1 cycles. Run length: sweeps*N*(N+PBIT_LAT+1) cycles.
- Updated state[i] is visible to node i+1's ACCUM (sequential Gibbs).
- start while busy: ignored. stop in IDLE: ignored. start and stop in same IDLE cycle: start wins, and stop is not latched.
- sweep_count wraps modulo 2^SWEEP_W when sweeps=0.
- sweep_done and done coincide on the final sweep.

Decomposition:
- Shared package pbit_pkg: Q8.24 width constants INT_SIZE/FLOAT_SIZE, saturated add/sub function, FSM state enum.
- One natural sub-module: pbit_field_accum. It holds acc, performs saturating signed add/sub with m_j selection, and loads the bias.
- The scheduler instantiates pbit_field_accum and the pbit datapath externally.

Test Plan:
- All J=0, h[3]=0x7F000000, sweeps=1, stub pbit_val=1 -> pbit_z=0x7F000000 during node 3 SETTLE; final state=0xFF; done 1+8*11=89 cycles after start.
- J[0][j]=0x01000000 for all j, state init 0x00, h=0 -> node 0 pbit_z=0xF9000000 (-7.0; diagonal skipped).
- All J=0x7F000000, h=0x7F000000, state init 0xFF -> pbit_z saturates to 0x7FFFFFFF. Negated J with state init 0x00 -> 0x7FFFFFFF. All h and J=0x80000000, state 0xFF -> 0x80000000.
- sweeps=2, N=8, PBIT_LAT=2 -> sweep_done at cycles 89 and 177; done with second pulse; sweep_count=2; busy low after.
- sweeps=0, stop asserted mid-ACCUM of node 5 -> node 5 completes SAMPLE, done pulses, no further state writes. cfg_we during busy leaves J unchanged.
- RST asserted mid-SETTLE -> immediately IDLE, busy=0, state=0x00, pbit_z=0, J/h cleared; subsequent start runs normally.
